regress_stim_check: RTL and testbench

- Self-checking stimulus/checker harness for regression tests. It is the driving and observing end of a device-under-test (DUT) port list.
- Generates a pseudo-random vector from a 64-bit LFSR each cycle and drives it into a DUT input bus.
- Folds the DUT output bus into a 64-bit signature. After a fixed cycle count, compares the signature against an expected constant and flags pass or fail.
- Sits at test top level, wrapped around any combinational or sequential DUT.

---
 rtl/regress_stim_check_pkg.sv | 22 ++
 rtl/lfsr64_step.sv | 13 +
 rtl/regress_stim_check.sv | 138 +++++++++++++
 tb/tb_regress_stim_check.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regress_stim_check_pkg.sv
// Shared types and LFSR helpers for the regression stimulus/checker harness.
// Latency: n/a (declarations only). Backpressure: n/a.
// Polynomial taps are x^63, x^2 and x^0, fed back into bit 0 after a left shift.
package regress_stim_check_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        WARM  = 3'd2,
        ACCUM = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [63:0] LFSR_TAPS    = 64'h8000_0000_0000_0005;
    localparam logic [63:0] DEFAULT_SEED = 64'h5aef0c8d_d70a4497;

    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        return {x[62:0], ^(x & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr64_step.sv
// One combinational step of the 64-bit stimulus/signature LFSR.
// Latency: 0 cycles (pure logic). Backpressure: none.
// Shared by the stimulus generator and the signature folder.
module lfsr64_step
    import regress_stim_check_pkg::*;
(
    input  logic [63:0] cur,
    output logic [63:0] nxt
);

    assign nxt = lfsr_next(cur);

endmodule

// File: rtl/regress_stim_check.sv
// LFSR stimulus driver and signature checker wrapped around a DUT; optional REGRESS_STIM_CHECK_SAMPLE_REG_EN adds a dut_result register.
// Latency: stim follows crc combinationally; dut_result folded same edge (or one edge later with the sample register).
// Backpressure: none -- free-running, one vector per clock until the check completes.
module regress_stim_check
    import regress_stim_check_pkg::*;
#(
    parameter int          DW      = 8,
    parameter int          CYCLES  = 99,
    parameter int          WARMUP  = 10,
    parameter logic [63:0] SEED    = DEFAULT_SEED,
    parameter logic [63:0] EXP_SUM = 64'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [DW-1:0] stim,
    input  logic [DW-1:0] dut_result,
    output logic [7:0]    cyc,
    output logic [63:0]   sum,
    output logic          done,
    output logic          pass,
    output logic          fail
);

    state_t        state;
    state_t        state_nxt;
    logic [63:0]   crc;
    logic [63:0]   crc_nxt;
    logic [63:0]   sum_nxt;
    logic [63:0]   res_ext;
    logic [DW-1:0] fold_in;
    logic [7:0]    cyc_inc;
    logic          load;
    logic          step;
    logic          acc;
    logic          chk;

`ifdef REGRESS_STIM_CHECK_SAMPLE_REG_EN
    // The extra flop delays dut_result by one cycle, so both phase boundaries shift by one.
    localparam logic [7:0] ACC_AT = 8'(WARMUP);
    localparam logic [7:0] CHK_AT = 8'(CYCLES);

    logic [DW-1:0] res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= dut_result;
        end
    end

    assign fold_in = res_q;
`else
    localparam logic [7:0] ACC_AT = 8'(WARMUP - 1);
    localparam logic [7:0] CHK_AT = 8'(CYCLES - 1);

    assign fold_in = dut_result;
`endif

    assign res_ext = 64'(fold_in);
    assign stim    = crc[DW-1:0];
    assign cyc_inc = (cyc == 8'hff) ? cyc : cyc + 8'd1;

    lfsr64_step u_crc_step (
        .cur (crc),
        .nxt (crc_nxt)
    );

    lfsr64_step u_sum_step (
        .cur (sum),
        .nxt (sum_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        acc       = 1'b0;
        chk       = 1'b0;
        case (state)
            IDLE:  state_nxt = INIT;
            INIT: begin
                load      = 1'b1;
                state_nxt = WARM;
            end
            WARM: begin
                step = 1'b1;
                if (cyc == ACC_AT) state_nxt = ACCUM;
            end
            ACCUM: begin
                step = 1'b1;
                acc  = 1'b1;
                if (cyc == CHK_AT) state_nxt = CHECK;
            end
            CHECK: begin
                chk       = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc  <= '0;
            sum  <= '0;
            cyc  <= '0;
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
        end else begin
            if (load) begin
                crc <= SEED;
                sum <= '0;
                cyc <= 8'd1;
            end else if (step) begin
                crc <= crc_nxt;
                cyc <= cyc_inc;
                sum <= acc ? (res_ext ^ sum_nxt) : 64'h0;
            end
            if (chk) begin
                done <= 1'b1;
                pass <= (sum == EXP_SUM);
                fail <= (sum != EXP_SUM);
            end
        end
    end

endmodule

// File: tb/tb_regress_stim_check.sv
// Bench for regress_stim_check: three harness copies (zero/random DUT, mismatch, loopback) share clock and reset.
module tb_regress_stim_check;

    localparam int          DW     = 8;
    localparam int          CYCLES = 99;
    localparam int          WARMUP = 10;
    localparam logic [63:0] SEED   = 64'h5aef0c8d_d70a4497;
`ifdef REGRESS_STIM_CHECK_SAMPLE_REG_EN
    localparam logic [7:0]  DONE_CYC = 8'(CYCLES + 1);
`else
    localparam logic [7:0]  DONE_CYC = 8'(CYCLES);
`endif

    function automatic logic [63:0] m_step(input logic [63:0] x);
        return {x[62:0], x[63] ^ x[2] ^ x[0]};
    endfunction

    // Signature of a loopback DUT: vector k (k = 1 at the first seeded cycle) is folded for k in [WARMUP, CYCLES-1].
    function automatic logic [63:0] m_loop_sum();
        logic [63:0] c;
        logic [63:0] s;
        c = SEED;
        s = 64'h0;
        for (int k = 1; k < CYCLES; k++) begin
            if (k >= WARMUP) s = {56'h0, c[7:0]} ^ m_step(s);
            c = m_step(c);
        end
        return s;
    endfunction

    localparam logic [63:0] LOOP_SUM = m_loop_sum();

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rnd_on = 1'b0;
    logic [7:0]    rnd [256];
    logic [DW-1:0] res_a, res_b, res_c;
    logic [DW-1:0] stim_a, stim_b, stim_c;
    logic [7:0]    cyc_a, cyc_b, cyc_c;
    logic [63:0]   sum_a, sum_b, sum_c;
    logic          done_a, done_b, done_c;
    logic          pass_a, pass_b, pass_c;
    logic          fail_a, fail_b, fail_c;
    int            checks = 0;
    int            errors = 0;
    logic [63:0]   run1_sum;

    always #5 clk = ~clk;

    assign res_a = rnd_on ? rnd[cyc_a] : 8'h00;
    assign res_b = 8'h00;
    assign res_c = stim_c;

    regress_stim_check #(.DW(DW), .CYCLES(CYCLES), .WARMUP(WARMUP), .SEED(SEED), .EXP_SUM(64'h0)) u_a (
        .clk(clk), .rst_n(rst_n), .stim(stim_a), .dut_result(res_a), .cyc(cyc_a),
        .sum(sum_a), .done(done_a), .pass(pass_a), .fail(fail_a));

    regress_stim_check #(.DW(DW), .CYCLES(CYCLES), .WARMUP(WARMUP), .SEED(SEED), .EXP_SUM(64'h1)) u_b (
        .clk(clk), .rst_n(rst_n), .stim(stim_b), .dut_result(res_b), .cyc(cyc_b),
        .sum(sum_b), .done(done_b), .pass(pass_b), .fail(fail_b));

    regress_stim_check #(.DW(DW), .CYCLES(CYCLES), .WARMUP(WARMUP), .SEED(SEED), .EXP_SUM(LOOP_SUM)) u_c (
        .clk(clk), .rst_n(rst_n), .stim(stim_c), .dut_result(res_c), .cyc(cyc_c),
        .sum(sum_c), .done(done_c), .pass(pass_c), .fail(fail_c));

    task automatic restart();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            if (done_c) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stim_a, cyc_a} !== 16'h0) begin
            errors++; $display("FAIL reset_stim_cyc got stim=%h cyc=%0d want 0/0", stim_a, cyc_a);
        end
        checks++;
        if ({sum_a, done_a, pass_a, fail_a} !== 67'h0) begin
            errors++; $display("FAIL reset_sum_flags got sum=%h d/p/f=%b%b%b want 0", sum_a, done_a, pass_a, fail_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({stim_a, cyc_a} !== 16'h0) begin
            errors++; $display("FAIL idle_to_init got stim=%h cyc=%0d want 00/0", stim_a, cyc_a);
        end
        @(negedge clk);
        checks++;
        if ({stim_a, cyc_a} !== {8'h97, 8'd1}) begin
            errors++; $display("FAIL init_load got stim=%h cyc=%0d want 97/1", stim_a, cyc_a);
        end
        @(negedge clk);
        checks++;
        if ({stim_a, cyc_a} !== {8'h2e, 8'd2}) begin
            errors++; $display("FAIL first_step got stim=%h cyc=%0d want 2e/2", stim_a, cyc_a);
        end
    endtask

    task automatic test_zero_dut();
        int nonzero = 0;
        for (int i = 0; i < 400; i++) begin
            if (sum_a !== 64'h0) nonzero++;
            if (done_a) break;
            @(negedge clk);
        end
        checks++;
        if (nonzero != 0) begin
            errors++; $display("FAIL zero_sum got %0d nonzero cycles want 0", nonzero);
        end
        checks++;
        if ({done_a, pass_a, fail_a} !== 3'b110) begin
            errors++; $display("FAIL zero_flags got d/p/f=%b%b%b want 110", done_a, pass_a, fail_a);
        end
        checks++;
        if (cyc_a !== DONE_CYC) begin
            errors++; $display("FAIL zero_done_cyc got %0d want %0d", cyc_a, DONE_CYC);
        end
    endtask

    task automatic test_mismatch();
        checks++;
        if ({done_b, pass_b, fail_b} !== 3'b101 || cyc_b !== DONE_CYC) begin
            errors++; $display("FAIL mismatch_flags got d/p/f=%b%b%b cyc=%0d want 101 cyc=%0d", done_b, pass_b, fail_b, cyc_b, DONE_CYC);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({done_b, pass_b, fail_b} !== 3'b101) begin
                errors++; $display("FAIL mismatch_sticky[%0d] got d/p/f=%b%b%b want 101", i, done_b, pass_b, fail_b);
            end
        end
    endtask

    task automatic test_loopback();
        checks++;
        if (sum_c !== LOOP_SUM || sum_c === 64'h0) begin
            errors++; $display("FAIL loopback_sum got %h want %h (nonzero)", sum_c, LOOP_SUM);
        end
        checks++;
        if ({done_c, pass_c, fail_c} !== 3'b110) begin
            errors++; $display("FAIL loopback_pass got d/p/f=%b%b%b want 110", done_c, pass_c, fail_c);
        end
        run1_sum = sum_c;
    endtask

    task automatic test_random_and_rerun();
        logic [63:0] exp_sum;
        for (int k = 0; k < 256; k++) rnd[k] = 8'($urandom);
        exp_sum = 64'h0;
        for (int k = WARMUP; k < CYCLES; k++) exp_sum = {56'h0, rnd[k]} ^ m_step(exp_sum);
        rnd_on = 1'b1;
        restart();
        wait_done();
        checks++;
        if (done_a !== 1'b1 || sum_a !== exp_sum) begin
            errors++; $display("FAIL random_sum got done=%b sum=%h want 1/%h", done_a, sum_a, exp_sum);
        end
        checks++;
        if ({pass_a, fail_a} !== {exp_sum == 64'h0, exp_sum != 64'h0}) begin
            errors++; $display("FAIL random_flags got p/f=%b%b want %b%b", pass_a, fail_a, exp_sum == 64'h0, exp_sum != 64'h0);
        end
        checks++;
        if (sum_c !== run1_sum || pass_c !== 1'b1) begin
            errors++; $display("FAIL rerun_sum got %h pass=%b want %h pass=1", sum_c, pass_c, run1_sum);
        end
        rnd_on = 1'b0;
    endtask

    task automatic test_midrun_reset();
        int hit = 0;
        restart();
        for (int i = 0; i < 200; i++) begin
            if (cyc_c == 8'd50) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (hit == 0) begin
            errors++; $display("FAIL midrun_reach got cyc=%0d want 50", cyc_c);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stim_c, cyc_c, sum_c, done_c, pass_c, fail_c} !== 83'h0) begin
            errors++; $display("FAIL midrun_async got stim=%h cyc=%0d sum=%h d/p/f=%b%b%b want all 0",
                               stim_c, cyc_c, sum_c, done_c, pass_c, fail_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_done();
        checks++;
        if (done_c !== 1'b1 || sum_c !== LOOP_SUM || pass_c !== 1'b1 || fail_c !== 1'b0) begin
            errors++; $display("FAIL midrun_rerun got done=%b sum=%h p/f=%b%b want 1/%h/10", done_c, sum_c, pass_c, fail_c, LOOP_SUM);
        end
        checks++;
        if (cyc_c !== DONE_CYC) begin
            errors++; $display("FAIL midrun_cyc got %0d want %0d", cyc_c, DONE_CYC);
        end
    endtask

    initial begin
        test_reset();
        test_zero_dut();
        test_mismatch();
        test_loopback();
        test_random_and_rerun();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
